addr_latch_incdec: RTL

- Address-side consumer of the register file. It latches the 16-bit value that a selected register (PC, SP, WZ, IR, BC, HL, IX, IY…) drives onto db_hi_as/db_lo_as.
- It drives the latched value onto the external address pins.
- It computes the value ±1 through a 16-bit incrementer/decrementer, with a 7-bit mode for refresh R.
- It returns the result to the address-side buses so the register file can store it back (PC++, SP--, BC--, HL±, R++).

---
 rtl/z80_addr_pkg.sv | 12 +
 rtl/inc_dec_16.sv | 33 +++
 rtl/addr_latch_incdec.sv | 102 ++++++++++
 3 files changed

// File: rtl/z80_addr_pkg.sv
// Shared address-path types and constants for the Z80 address latch and its
// +/-1 unit.
package z80_addr_pkg;
  localparam int          ADDR_W = 16;
  localparam logic [15:0] R_MASK = 16'h007F;

  typedef enum logic [1:0] {
    DRIVE,
    FLOAT_PEND,
    FLOATED
  } addr_float_t;
endpackage

// File: rtl/inc_dec_16.sv
// Combinational +/-1 unit. In R mode only bits [6:0] step; the upper bits,
// including R[7], pass through unchanged.
module inc_dec_16
  import z80_addr_pkg::*;
(
  input  logic [ADDR_W-1:0] din,
  input  logic              cy,
  input  logic              dec,
  input  logic              limit7,
  output logic [ADDR_W-1:0] dout,
  output logic              wrap
);

  logic [ADDR_W-1:0] full_step;
  logic [6:0]        low_step;

  always_comb begin
    full_step = dec ? (din - ADDR_W'(1)) : (din + ADDR_W'(1));
    low_step  = dec ? (din[6:0] - 7'd1) : (din[6:0] + 7'd1);
    dout      = din;
    wrap      = 1'b0;
    if (cy) begin
      if (limit7) begin
        dout = (din & ~R_MASK) | {{(ADDR_W-7){1'b0}}, low_step};
        wrap = dec ? (din[6:0] == 7'h00) : (din[6:0] == 7'h7F);
      end else begin
        dout = full_step;
        wrap = dec ? (din == '0) : (din == '1);
      end
    end
  end

endmodule

// File: rtl/addr_latch_incdec.sv
// Address latch, pin driver and +/-1 writeback path between the register
// file's address-side buses and the external address pins.
//
// state      | meaning
// DRIVE      | pins driven, latch loads on ctl_al_we
// FLOAT_PEND | one-cycle float hold, pins still driven, latch frozen
// FLOATED    | pins released, latch frozen
module addr_latch_incdec
  import z80_addr_pkg::*;
#(
  parameter int AW = ADDR_W
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic [7:0]    db_lo_as_in,
  input  logic [7:0]    db_hi_as_in,
  output logic [7:0]    db_lo_as_out,
  output logic [7:0]    db_hi_as_out,
  output logic          db_as_oe,
  input  logic          ctl_al_we,
  input  logic          ctl_inc_go,
  input  logic          ctl_inc_cy,
  input  logic          ctl_inc_dec,
  input  logic          ctl_inc_limit7,
  input  logic          ctl_al_oe,
  input  logic          ctl_bus_float,
  output logic [AW-1:0] abus,
  output logic          abus_oe,
  output logic          address_is_1,
  output logic          inc_wrap
);

  addr_float_t       state_q, state_d;
  logic [ADDR_W-1:0] latch_q, latch_d;
  logic [ADDR_W-1:0] result_q, result_d;
  logic              inc_wrap_q, inc_wrap_d;
  logic              db_as_oe_q, db_as_oe_d;
  logic              address_is_1_q, address_is_1_d;
  logic [ADDR_W-1:0] inc_value;
  logic              inc_wrap_now;

  inc_dec_16 u_inc_dec (
    .din    (latch_q),
    .cy     (ctl_inc_cy),
    .dec    (ctl_inc_dec),
    .limit7 (ctl_inc_limit7),
    .dout   (inc_value),
    .wrap   (inc_wrap_now)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DRIVE:      if (ctl_bus_float) state_d = FLOAT_PEND;
      FLOAT_PEND: state_d = FLOATED;
      FLOATED:    if (!ctl_bus_float) state_d = DRIVE;
      default:    state_d = FLOATED;
    endcase
  end

  always_comb begin
    latch_d        = latch_q;
    result_d       = result_q;
    inc_wrap_d     = inc_wrap_q;
    if (ctl_al_we && (state_q == DRIVE)) latch_d = {db_hi_as_in, db_lo_as_in};
    // Capture reads the pre-load latch, so a same-cycle load does not leak in.
    if (ctl_inc_go) begin
      result_d   = inc_value;
      inc_wrap_d = inc_wrap_now;
    end
    db_as_oe_d     = ctl_al_oe;
    address_is_1_d = (latch_d == ADDR_W'(1));
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q        <= FLOATED;
      latch_q        <= '0;
      result_q       <= '0;
      inc_wrap_q     <= 1'b0;
      db_as_oe_q     <= 1'b0;
      address_is_1_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      latch_q        <= latch_d;
      result_q       <= result_d;
      inc_wrap_q     <= inc_wrap_d;
      db_as_oe_q     <= db_as_oe_d;
      address_is_1_q <= address_is_1_d;
    end
  end

  // Never drive the buses in a cycle where they are being sampled.
  assign db_as_oe     = db_as_oe_q & ~ctl_al_we;
  assign db_lo_as_out = result_q[7:0];
  assign db_hi_as_out = result_q[15:8];
  assign abus         = latch_q;
  assign abus_oe      = (state_q != FLOATED);
  assign address_is_1 = address_is_1_q;
  assign inc_wrap     = inc_wrap_q;

endmodule
